// File: rtl/gato_auto_player.sv
// Automatic O player for the tic-tac-toe board: scans the lines, picks a cell,
// steps the cursor there with mover pulses and drops an O with colocar.
module gato_auto_player #(
    parameter int GAP          = 2,
    parameter int STEP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        jugador,
    input  logic [3:0]  posActual,
    input  logic [17:0] matrizDeJuego,
    output logic        mover,
    output logic        colocar,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, SCAN, PICK, STEP, WAITPOS, GAPW, PLACE, DONE} state_t;

    localparam logic [7:0] GAP_L = 8'(GAP - 1);
    localparam logic [7:0] TMO_L = 8'(STEP_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  line_q, line_d;
    logic        win_v_q, win_v_d, blk_v_q, blk_v_d;
    logic [3:0]  win_c_q, win_c_d, blk_c_q, blk_c_d;
    logic [3:0]  target_q, target_d, steps_q, steps_d, pos_ref_q, pos_ref_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        seen_q, seen_d;
    logic        mover_q, mover_d, colocar_q, colocar_d, err_q, err_d;

    function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
        logic [1:0] c;
        c = 2'b11;
        for (int i = 0; i < 9; i++)
            if (k == 4'(i)) c = b[2*i +: 2];
        return c;
    endfunction

    function automatic logic [11:0] line_cells(input logic [2:0] l);
        case (l)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    logic [8:0]  empty_v;
    logic [11:0] lc;
    logic [1:0]  va, vb, vc, n_o, n_x, n_e;
    logic [3:0]  ecell, tgt, diff, sc;
    logic        abort;

    always_comb begin
        for (int k = 0; k < 9; k++) empty_v[k] = (matrizDeJuego[2*k +: 2] == 2'b00);
        lc    = line_cells(line_q);
        va    = cell_of(matrizDeJuego, lc[11:8]);
        vb    = cell_of(matrizDeJuego, lc[7:4]);
        vc    = cell_of(matrizDeJuego, lc[3:0]);
        n_o   = 2'(va == 2'b10) + 2'(vb == 2'b10) + 2'(vc == 2'b10);
        n_x   = 2'(va == 2'b01) + 2'(vb == 2'b01) + 2'(vc == 2'b01);
        n_e   = 2'(va == 2'b00) + 2'(vb == 2'b00) + 2'(vc == 2'b00);
        ecell = (va == 2'b00) ? lc[11:8] : (vb == 2'b00) ? lc[7:4] : lc[3:0];
        abort = jugador || !enable;

        if (win_v_q)         tgt = win_c_q;
        else if (blk_v_q)    tgt = blk_c_q;
        else if (empty_v[4]) tgt = 4'd4;
        else if (empty_v[0]) tgt = 4'd0;
        else if (empty_v[2]) tgt = 4'd2;
        else if (empty_v[6]) tgt = 4'd6;
        else if (empty_v[8]) tgt = 4'd8;
        else if (empty_v[1]) tgt = 4'd1;
        else if (empty_v[3]) tgt = 4'd3;
        else if (empty_v[5]) tgt = 4'd5;
        else if (empty_v[7]) tgt = 4'd7;
        else                 tgt = 4'd4;   // board filled mid-scan; PLACE will flag it
        diff = tgt - posActual;
        sc   = (tgt < posActual) ? diff + 4'd9 : diff;
    end

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        win_v_d   = win_v_q;
        win_c_d   = win_c_q;
        blk_v_d   = blk_v_q;
        blk_c_d   = blk_c_q;
        target_d  = target_q;
        steps_d   = steps_q;
        pos_ref_d = pos_ref_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        mover_d   = 1'b0;
        colocar_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: if (!abort && |empty_v) begin
                state_d = SCAN;
                line_d  = 3'd0;
                win_v_d = 1'b0;
                blk_v_d = 1'b0;
            end
            SCAN: if (abort) state_d = IDLE;
            else begin
                if (!win_v_q && n_o == 2'd2 && n_e == 2'd1) begin
                    win_v_d = 1'b1;
                    win_c_d = ecell;
                end
                if (!blk_v_q && n_x == 2'd2 && n_e == 2'd1) begin
                    blk_v_d = 1'b1;
                    blk_c_d = ecell;
                end
                if (line_q == 3'd7) state_d = PICK;
                else                line_d  = line_q + 3'd1;
            end
            PICK: if (abort) state_d = IDLE;
            else begin
                target_d = tgt;
                steps_d  = sc;
                state_d  = (sc == 4'd0) ? PLACE : STEP;
            end
            STEP: if (abort) state_d = IDLE;
            else begin
                mover_d   = 1'b1;
                steps_d   = steps_q - 4'd1;
                pos_ref_d = posActual;
                cnt_d     = 8'd0;
                state_d   = WAITPOS;
            end
            WAITPOS: if (abort) state_d = IDLE;
            else if (posActual != pos_ref_q) begin
                cnt_d   = 8'd0;
                state_d = GAPW;
            end else if (cnt_q == TMO_L) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else cnt_d = cnt_q + 8'd1;
            GAPW: if (abort) state_d = IDLE;
            else if (cnt_q == GAP_L) state_d = (steps_q != 4'd0) ? STEP : PLACE;
            else cnt_d = cnt_q + 8'd1;
            PLACE: if (abort) state_d = IDLE;
            else if (cell_of(matrizDeJuego, target_q) == 2'b00) begin
                colocar_d = 1'b1;
                seen_d    = 1'b0;
                cnt_d     = 8'd0;
                state_d   = DONE;
            end else begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            // Turn must be handed back before re-arming, so one O per turn.
            DONE: begin
                if (jugador) seen_d = 1'b1;
                if (seen_q) begin
                    if (cnt_q == GAP_L) state_d = IDLE;
                    else                cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            line_q    <= '0;
            win_v_q   <= 1'b0;
            win_c_q   <= '0;
            blk_v_q   <= 1'b0;
            blk_c_q   <= '0;
            target_q  <= '0;
            steps_q   <= '0;
            pos_ref_q <= '0;
            cnt_q     <= '0;
            seen_q    <= 1'b0;
            mover_q   <= 1'b0;
            colocar_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            win_v_q   <= win_v_d;
            win_c_q   <= win_c_d;
            blk_v_q   <= blk_v_d;
            blk_c_q   <= blk_c_d;
            target_q  <= target_d;
            steps_q   <= steps_d;
            pos_ref_q <= pos_ref_d;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            mover_q   <= mover_d;
            colocar_q <= colocar_d;
            err_q     <= err_d;
        end
    end

    assign mover   = mover_q;
    assign colocar = colocar_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_gato_auto_player.sv
// Directed bench for gato_auto_player with a simple cursor model driven by mover.
module tb_gato_auto_player;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst, enable, jugador;
    logic [3:0]  posActual;
    logic [17:0] matrizDeJuego;
    logic        mover, colocar, busy, err;
    logic        pos_ld, stuck;
    logic [3:0]  ld_val;
    int          n_cmp = 0, n_err = 0;

    gato_auto_player #(.GAP(GAP), .STEP_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .jugador(jugador),
        .posActual(posActual), .matrizDeJuego(matrizDeJuego),
        .mover(mover), .colocar(colocar), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pos_ld)               posActual <= ld_val;
        else if (mover && !stuck) posActual <= (posActual == 4'd8) ? 4'd0 : posActual + 4'd1;
    end

    typedef struct {
        string      bs;
        logic [3:0] pos;
        logic       stk;
        int         mov;
        int         col;
        int         ev;    // 0 none, 1 colocar, 2 err
        int         lat;   // cycles from busy rising to the event
        logic [3:0] fpos;
        logic       ferr;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [17:0] bd(input string s);
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++)
            if (s[k] == "X")      b[2*k +: 2] = 2'b01;
            else if (s[k] == "O") b[2*k +: 2] = 2'b10;
        return b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input string bs, input logic [3:0] p, input logic stk);
        rst = 1'b1; enable = 1'b1; jugador = 1'b1; stuck = stk;
        matrizDeJuego = bd(bs); ld_val = p; pos_ld = 1'b1;
        @(posedge clk); @(negedge clk);
        pos_ld = 1'b0; rst = 1'b0;
        @(negedge clk);
        jugador = 1'b0;
    endtask

    task automatic wait_mover(output int ok);
        ok = 0;
        for (int c = 0; c < 60 && ok == 0; c++) begin
            @(negedge clk);
            if (mover) ok = 1;
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int nmov, ncol, ovl, brise, endt, last, minsp, extra, maxc;
        logic [3:0] epos;
        logic stop;
        v = vecs[i];
        nmov = 0; ncol = 0; ovl = 0; brise = -1; endt = -1; last = -1;
        minsp = 1000; extra = 0; epos = 4'hF; stop = 1'b0;
        maxc = (v.ev == 0) ? 40 : 200;
        start(v.bs, v.pos, v.stk);
        for (int c = 0; c < maxc && !stop; c++) begin
            @(negedge clk);
            if (busy && brise < 0) brise = c;
            if (mover && colocar) ovl++;
            if (mover) begin
                nmov++;
                if (last >= 0 && c - last < minsp) minsp = c - last;
                last = c;
            end
            if (colocar) begin ncol++; epos = posActual; end
            if (colocar || err) begin endt = c; stop = 1'b1; end
        end
        jugador = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mover || colocar) extra++;
        end
        chk($sformatf("v%0d mover_count", i), nmov, v.mov);
        chk($sformatf("v%0d colocar_count", i), ncol, v.col);
        chk($sformatf("v%0d err", i), int'(err), int'(v.ferr));
        chk($sformatf("v%0d overlap", i), ovl, 0);
        chk($sformatf("v%0d pulses_after_turn", i), extra, 0);
        if (v.ev == 0) chk($sformatf("v%0d busy_seen", i), brise, -1);
        else           chk($sformatf("v%0d latency", i), (endt < 0) ? -1 : endt - brise, v.lat);
        if (v.ev == 1) chk($sformatf("v%0d target", i), int'(epos), int'(v.fpos));
        if (v.mov >= 2) chk($sformatf("v%0d spacing_gt_gap", i), int'(minsp > GAP), 1);
    endtask

    initial begin
        int ok, n;
        vecs[0] = '{"OO.XX....", 4'd0, 1'b0, 2, 1, 1, 20, 4'd2, 1'b0};
        vecs[1] = '{"....O.XX.", 4'd1, 1'b0, 7, 1, 1, 45, 4'd8, 1'b0};
        vecs[2] = '{".........", 4'd4, 1'b0, 0, 1, 1, 10, 4'd4, 1'b0};
        vecs[3] = '{".........", 4'd0, 1'b1, 1, 0, 2, 18, 4'd0, 1'b1};
        vecs[4] = '{"XOXXOOOXX", 4'd0, 1'b0, 0, 0, 0, 0,  4'd0, 1'b0};
        vecs[5] = '{"X.O.O.O.X", 4'd0, 1'b0, 1, 1, 1, 15, 4'd1, 1'b0};
        vecs[6] = '{"XX....O.O", 4'd7, 1'b0, 0, 1, 1, 10, 4'd7, 1'b0};
        vecs[7] = '{"XX.......", 4'd8, 1'b0, 3, 1, 1, 25, 4'd2, 1'b0};
        vecs[8] = '{"....X....", 4'd0, 1'b0, 0, 1, 1, 10, 4'd0, 1'b0};

        rst = 1'b1; enable = 1'b0; jugador = 1'b1; stuck = 1'b0;
        pos_ld = 1'b0; ld_val = 4'd0; matrizDeJuego = '0;
        #1;
        chk("reset_outputs", int'({mover, colocar, busy, err}), 0);

        for (int i = 0; i < 9; i++) run_vec(i);

        // Abort while the block sits in STEP: no further mover pulse.
        start(".........", 4'd0, 1'b0);
        wait_mover(ok);
        chk("abort first_mover", ok, 1);
        repeat (4) @(negedge clk);
        jugador = 1'b1;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (mover || colocar) n++;
        end
        chk("abort pulses", n, 0);
        chk("abort busy", int'(busy), 0);

        // Async reset during WAITPOS, then release mid-turn.
        start(".........", 4'd0, 1'b1);
        wait_mover(ok);
        chk("rst first_mover", ok, 1);
        #2 rst = 1'b1;
        #1 chk("rst async_outputs", int'({mover, colocar, busy, err}), 0);
        @(negedge clk);
        stuck = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("rst release_scan", int'(busy), 1);

        // Target taken during stepping: err, no colocar.
        start(".........", 4'd0, 1'b0);
        wait_mover(ok);
        chk("occupied first_mover", ok, 1);
        matrizDeJuego = bd("....X....");
        n = 0; ok = 0;
        for (int c = 0; c < 100 && ok == 0; c++) begin
            @(negedge clk);
            if (colocar) n++;
            if (err) ok = 1;
        end
        chk("occupied err", ok, 1);
        chk("occupied colocar", n, 0);
        jugador = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gato_auto_player.md
GATO_AUTO_PLAYER -- requirements
Module: gato_auto_player

Interface
REQ-001 Parameter GAP, default 2, is the idle cycles after each mover/colocar pulse before the next action (range 1..15).
REQ-002 Parameter STEP_TIMEOUT, default 8, is the cycles to wait for posActual to change after a mover pulse before declaring an error.
REQ-003 clk  input  1  system clock; all state on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  1 = automatic player controls O; 0 = block idle, outputs held 0.
REQ-006 jugador  input  1  current turn (1: X, 0: O); the block plays only when 0.
REQ-007 posActual  input  4  cursor position 0..8, driven by the move logic.
REQ-008 matrizDeJuego  input  18  board, cell k at bits [2k+1:2k]; 00 empty, 01 X, 10 O, 11 treated as occupied.
REQ-009 mover  output  1  single-cycle pulse; advances the cursor by one, 8 wraps to 0.
REQ-010 colocar  output  1  single-cycle pulse; places O at the cursor.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  sticky; set on step timeout or target occupied; cleared only by rst.

Function
REQ-013 FSM states: IDLE, SCAN, PICK, STEP, WAITPOS, GAPW, PLACE, DONE.
REQ-014 IDLE -> SCAN when enable=1, jugador=0 and the board has at least one empty cell; a full board stays in IDLE.
REQ-015 SCAN evaluates one line per cycle, 8 cycles, order: rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6.
REQ-016 For each line, SCAN records the first line holding two O and one empty cell (win candidate) and the first line holding two X and one empty cell (block candidate); the empty cell index is stored with each.
REQ-017 PICK (1 cycle) selects the target by priority: win candidate, then block candidate, then cell 4 if empty, then the first empty of 0,2,6,8, then the first empty of 1,3,5,7.
REQ-018 Step count = (target - posActual) mod 9, computed with 4-bit arithmetic in the range 0..8.
REQ-019 If the step count is 0, PICK -> PLACE; otherwise PICK -> STEP.
REQ-020 STEP asserts mover for exactly 1 cycle, decrements the remaining count, then goes to WAITPOS.
REQ-021 WAITPOS -> GAPW when posActual differs from its value at the pulse.
REQ-022 After STEP_TIMEOUT cycles with no posActual change, WAITPOS sets err and goes to IDLE.
REQ-023 GAPW waits GAP cycles, then goes to STEP if the remaining count is above 0, else to PLACE.
REQ-024 PLACE re-checks the target cell. If empty, PLACE asserts colocar for 1 cycle and goes to DONE. Otherwise PLACE sets err, emits no pulse and goes to IDLE.
REQ-025 DONE holds until jugador=1, then waits GAP cycles and returns to IDLE; the block never places twice in one turn.
REQ-026 Abort: jugador=1 or enable=0 in any state except DONE returns to IDLE next cycle with no further pulses; a pulse already asserted in that cycle completes.
REQ-027 mover and colocar are never high in the same cycle; both are registered outputs.
REQ-028 Board input is sampled live in SCAN; a change during SCAN is not rescanned.

Reset
REQ-029 rst=1 forces state IDLE and clears the step count, candidates, target, gap counter, mover, colocar, busy and err to 0 immediately, regardless of clk.
REQ-030 Release of rst mid-turn with jugador=0 and enable=1 starts a fresh SCAN on the first clock edge.

Verification
REQ-031 Win: board with O at 0 and 1, X at 3 and 4, posActual=0, jugador=0 -> target 2; 2 mover pulses each GAP+ apart, then 1 colocar.
REQ-032 Block with wrap: X at 6 and 7, O at 4, cell 8 empty, posActual=1 -> target 8; 7 mover pulses, then colocar; no pulse after jugador goes to 1.
REQ-033 Empty board, posActual=4 -> target 4; 0 mover pulses; colocar 10 cycles after the trigger (8 SCAN + PICK + PLACE).
REQ-034 Stuck cursor: posActual held constant -> 1 mover pulse, err=1 after STEP_TIMEOUT=8 cycles, busy=0, no colocar.
REQ-035 Abort/reset: jugador toggles to 1 mid-STEP -> IDLE, no further pulses; rst asserted mid-WAITPOS -> all outputs 0 asynchronously.
REQ-036 Full board with jugador=0 -> busy stays 0; mover and colocar never pulse.
